img_reader: RTL and testbench

IMG_READER -- requirements
Module: img_reader

---
 rtl/img_pkg.sv | 27 ++
 rtl/img_reader_if.sv | 12 +
 rtl/sync_delay.sv | 26 ++
 rtl/img_reader.sv | 96 +++++++++
 tb/tb_img_reader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image geometry and RGB565 field layout for the ROM, the reader and the VGA top.
package img_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);

  // Top bit of each RGB565 field; the reader keeps the upper 4 bits of each.
  localparam int RED_MSB   = 15;
  localparam int GREEN_MSB = 10;
  localparam int BLUE_MSB  = 4;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb444_t;

  function automatic rgb444_t rgb565_to_444(input logic [15:0] px);
    rgb444_t c;
    c.red   = px[RED_MSB   -: 4];
    c.green = px[GREEN_MSB -: 4];
    c.blue  = px[BLUE_MSB  -: 4];
    return c;
  endfunction

endpackage

// File: rtl/img_reader_if.sv
// Image ROM read port: registered address out, data back one cycle later.
interface img_reader_if #(
  parameter int ADDR_W = img_pkg::ADDR_W
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);

endinterface

// File: rtl/sync_delay.sv
// N-stage register pipeline with a per-bit reset value, used to align syncs/enable to colour.
module sync_delay #(
  parameter int             N       = 2,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) stg[i] <= RST_VAL;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[N-1];

endmodule

// File: rtl/img_reader.sv
// 2x upscaling image reader: walks the ROM address so each pixel and each line is shown twice.
module img_reader
  import img_pkg::*;
#(
  parameter int IMG_W  = img_pkg::IMG_W,
  parameter int IMG_H  = img_pkg::IMG_H,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_de,
  input  logic                i_hsync,
  input  logic                i_vsync,
  img_reader_if.master        rom,
  output logic [3:0]          o_red,
  output logic [3:0]          o_green,
  output logic [3:0]          o_blue,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_de,
  output logic                dbg_x_phase,
  output logic                dbg_y_phase,
  output logic                dbg_frame_end
);

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] line_base;
  logic              x_phase;
  logic              y_phase;
  logic              de_d;
  rgb444_t           px_c;

  // Vsync wins over everything; otherwise the falling edge of de decides replay vs advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      line_base <= '0;
      x_phase   <= 1'b0;
      y_phase   <= 1'b0;
      de_d      <= 1'b0;
    end else begin
      de_d <= i_de;
      if (!i_vsync) begin
        addr      <= '0;
        line_base <= '0;
        x_phase   <= 1'b0;
        y_phase   <= 1'b0;
      end else if (i_de) begin
        x_phase <= ~x_phase;
        if (x_phase) addr <= addr + ADDR_W'(1);
      end else if (de_d) begin
        x_phase <= 1'b0;
        y_phase <= ~y_phase;
        if (!y_phase) addr      <= line_base;
        else          line_base <= addr;
      end
    end
  end

  assign rom.rom_addr = addr;

  // de_d lines up with rom_data, so it gates the colour register directly.
  assign px_c = rgb565_to_444(rom.rom_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else if (de_d) begin
      o_red   <= px_c.red;
      o_green <= px_c.green;
      o_blue  <= px_c.blue;
    end else begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end
  end

  sync_delay #(
    .N       (2),
    .W       (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({i_hsync, i_vsync, i_de}),
    .q     ({o_hsync, o_vsync, o_de})
  );

  assign dbg_x_phase   = x_phase;
  assign dbg_y_phase   = y_phase;
  assign dbg_frame_end = (addr == ADDR_W'(IMG_W * IMG_H));

endmodule

// File: tb/tb_img_reader.sv
// Directed bench for img_reader: default 320x240 instance plus a 4x3 instance for full-frame wrap.
module tb_img_reader;

  localparam int HBL = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Default-geometry instance
  logic de, hs, vs, rom_force;
  logic [3:0] o_red, o_green, o_blue;
  logic o_hsync, o_vsync, o_de, dbg_x, dbg_y, dbg_end;
  img_reader_if #(.ADDR_W(17)) rif ();

  // Small 4x3 instance
  logic de_s, hs_s, vs_s;
  logic [3:0] o_red_s, o_green_s, o_blue_s;
  logic o_hsync_s, o_vsync_s, o_de_s, dbg_x_s, dbg_y_s, dbg_end_s;
  img_reader_if #(.ADDR_W(4)) rif_s ();

  img_reader dut (
    .clk(clk), .reset(reset), .i_de(de), .i_hsync(hs), .i_vsync(vs), .rom(rif),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .dbg_x_phase(dbg_x), .dbg_y_phase(dbg_y), .dbg_frame_end(dbg_end)
  );

  img_reader #(.IMG_W(4), .IMG_H(3), .ADDR_W(4)) dut_s (
    .clk(clk), .reset(reset), .i_de(de_s), .i_hsync(hs_s), .i_vsync(vs_s), .rom(rif_s),
    .o_red(o_red_s), .o_green(o_green_s), .o_blue(o_blue_s),
    .o_hsync(o_hsync_s), .o_vsync(o_vsync_s), .o_de(o_de_s),
    .dbg_x_phase(dbg_x_s), .dbg_y_phase(dbg_y_s), .dbg_frame_end(dbg_end_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: address as data, except pixel 0 which is magenta
  always @(posedge clk) begin
    if (rom_force)               rif.rom_data <= 16'hFFFF;
    else if (rif.rom_addr == 0)  rif.rom_data <= 16'hF81F;
    else                         rif.rom_data <= rif.rom_addr[15:0];
    rif_s.rom_data <= {12'h000, rif_s.rom_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic def_line(input int base, input bit check, input bit lat);
    for (int i = 0; i < 640; i++) begin
      de = 1'b1;
      if (check) chk("line_addr", 32'(rif.rom_addr), 32'(base + i / 2));
      if (lat && i == 1) begin
        chk("lat_de_early", 32'(o_de), 32'd0);
        chk("lat_red_early", 32'(o_red), 32'd0);
      end
      if (lat && i == 2) begin
        chk("lat_red", 32'(o_red), 32'hF);
        chk("lat_green", 32'(o_green), 32'h0);
        chk("lat_blue", 32'(o_blue), 32'hF);
        chk("lat_de", 32'(o_de), 32'd1);
      end
      if (lat && i == 10) chk("mid_blue", 32'(o_blue), 32'h2);
      tick();
    end
    de = 1'b0;
    repeat (HBL) tick();
  endtask

  task automatic small_line(input int base);
    for (int i = 0; i < 8; i++) begin
      de_s = 1'b1;
      chk("small_addr", 32'(rif_s.rom_addr), 32'(base + i / 2));
      chk("small_range", 32'(rif_s.rom_addr <= 4'd11), 32'd1);
      tick();
    end
    de_s = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; rom_force = 1'b0;
    de = 1'b0; hs = 1'b1; vs = 1'b1;
    de_s = 1'b0; hs_s = 1'b1; vs_s = 1'b1;
    repeat (2) tick();

    chk("rst_addr", 32'(rif.rom_addr), 32'd0);
    chk("rst_red", 32'(o_red), 32'd0);
    chk("rst_green", 32'(o_green), 32'd0);
    chk("rst_blue", 32'(o_blue), 32'd0);
    chk("rst_de", 32'(o_de), 32'd0);
    chk("rst_hsync", 32'(o_hsync), 32'd1);
    chk("rst_vsync", 32'(o_vsync), 32'd1);
    reset = 1'b0;
    tick();

    // Vsync pulse, delayed by two stages
    vs = 1'b0; tick();
    chk("vs_stage1", 32'(o_vsync), 32'd1);
    tick();
    chk("vs_stage2", 32'(o_vsync), 32'd0);
    vs = 1'b1; tick(); tick();
    chk("vs_release", 32'(o_vsync), 32'd1);
    chk("vs_addr", 32'(rif.rom_addr), 32'd0);

    // Hsync pulse, delayed by two stages
    hs = 1'b0; tick();
    chk("hs_stage1", 32'(o_hsync), 32'd1);
    hs = 1'b1; tick();
    chk("hs_stage2", 32'(o_hsync), 32'd0);
    tick();
    chk("hs_release", 32'(o_hsync), 32'd1);

    // Line replay: 0..319, 0..319, then 320..
    def_line(0, 1'b1, 1'b1);
    rom_force = 1'b1;
    tick(); tick();
    chk("blank_red", 32'(o_red), 32'd0);
    chk("blank_green", 32'(o_green), 32'd0);
    chk("blank_blue", 32'(o_blue), 32'd0);
    chk("blank_de", 32'(o_de), 32'd0);
    rom_force = 1'b0;
    def_line(0, 1'b1, 1'b0);
    def_line(320, 1'b1, 1'b0);

    // Small instance: full frame, end address only in blanking, vsync wraps
    vs_s = 1'b0; tick(); tick();
    vs_s = 1'b1; tick();
    for (int l = 0; l < 6; l++) small_line((l / 2) * 4);
    chk("small_end_addr", 32'(rif_s.rom_addr), 32'd12);
    chk("small_frame_end", 32'(dbg_end_s), 32'd1);
    vs_s = 1'b0; tick();
    chk("small_wrap_addr", 32'(rif_s.rom_addr), 32'd0);
    chk("small_wrap_end", 32'(dbg_end_s), 32'd0);
    vs_s = 1'b1; tick();

    // Run on to line 100, pixel 200, then reset mid-line
    for (int l = 3; l < 100; l++) def_line(0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      de = 1'b1;
      if (i >= 198) hs = 1'b0;
      tick();
    end
    chk("l100_addr", 32'(rif.rom_addr), 32'd16100);
    chk("l100_red", 32'(o_red), 32'h3);
    chk("l100_green", 32'(o_green), 32'hD);
    chk("l100_blue", 32'(o_blue), 32'h1);
    chk("l100_hsync", 32'(o_hsync), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(rif.rom_addr), 32'd0);
    chk("mid_rst_red", 32'(o_red), 32'd0);
    chk("mid_rst_green", 32'(o_green), 32'd0);
    chk("mid_rst_blue", 32'(o_blue), 32'd0);
    chk("mid_rst_de", 32'(o_de), 32'd0);
    chk("mid_rst_hsync", 32'(o_hsync), 32'd1);
    chk("mid_rst_vsync", 32'(o_vsync), 32'd1);
    de = 1'b0; hs = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    vs = 1'b0; tick(); tick();
    vs = 1'b1; repeat (HBL) tick();
    def_line(0, 1'b1, 1'b1);
    def_line(0, 1'b1, 1'b0);

    // Vsync arriving mid-line forces the address back to 0
    for (int i = 0; i < 50; i++) begin
      de = 1'b1;
      tick();
    end
    chk("pre_vs_addr", 32'(rif.rom_addr), 32'd345);
    vs = 1'b0;
    tick();
    chk("mid_vs_addr", 32'(rif.rom_addr), 32'd0);
    de = 1'b0;
    tick(); tick();
    vs = 1'b1;
    repeat (HBL) tick();
    def_line(0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
